// File: rtl/reg_file_io.sv
// reg_file_io: DEPTH x WIDTH register file with one write port, two registered read ports and
// memory-mapped I/O at the top of the map. Define REGF_ZERO_REG_EN to hardwire address 0 to zero.
module reg_file_io #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int IN_PORTS  = 1,
  parameter int OUT_PORTS = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          WE,
  input  logic [AW-1:0]                 WSEL,
  input  logic [WIDTH-1:0]              IN,
  input  logic [AW-1:0]                 RSEL_A,
  input  logic [AW-1:0]                 RSEL_B,
  output logic [WIDTH-1:0]              OUT_A,
  output logic [WIDTH-1:0]              OUT_B,
  input  logic [IN_PORTS*WIDTH-1:0]     PORT_IN,
  output logic [OUT_PORTS*WIDTH-1:0]    PORT_OUT,
  output logic [IN_PORTS-1:0]           PORT_CHG,
  output logic                          WERR
);

  // Map: general registers [0, OUT_BASE), output ports [OUT_BASE, IN_BASE), input ports [IN_BASE, DEPTH).
  localparam int IN_BASE  = DEPTH - IN_PORTS;
  localparam int OUT_BASE = IN_BASE - OUT_PORTS;
  localparam logic [AW:0] IN_BASE_W = (AW+1)'(IN_BASE);

  logic [WIDTH-1:0] mem   [IN_BASE];
  logic [WIDTH-1:0] sync1 [IN_PORTS];
  logic [WIDTH-1:0] preg  [IN_PORTS];

  logic             wr_in_range;
  logic             wr_zero;
  logic             wr_ok;
  logic             wr_bad;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  assign wr_in_range = ({1'b0, WSEL} < IN_BASE_W);
`ifdef REGF_ZERO_REG_EN
  assign wr_zero = (WSEL == '0);
`else
  assign wr_zero = 1'b0;
`endif
  assign wr_ok  = WE && wr_in_range && !wr_zero;
  assign wr_bad = WE && !wr_in_range;

  // Unmatched (out-of-range) addresses fall through to zero; a legal write wins over stored data.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < IN_BASE; i++) begin
      if (RSEL_A == AW'(i)) rd_a = mem[i];
      if (RSEL_B == AW'(i)) rd_b = mem[i];
    end
    for (int i = 0; i < IN_PORTS; i++) begin
      if (RSEL_A == AW'(IN_BASE + i)) rd_a = preg[i];
      if (RSEL_B == AW'(IN_BASE + i)) rd_b = preg[i];
    end
    if (wr_ok && (RSEL_A == WSEL)) rd_a = IN;
    if (wr_ok && (RSEL_B == WSEL)) rd_b = IN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < IN_BASE; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < IN_BASE; i++) begin
        if (wr_ok && (WSEL == AW'(i))) mem[i] <= IN;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < IN_PORTS; i++) begin
        sync1[i] <= '0;
        preg[i]  <= '0;
      end
      PORT_CHG <= '0;
    end else begin
      for (int i = 0; i < IN_PORTS; i++) begin
        sync1[i]    <= PORT_IN[i*WIDTH +: WIDTH];
        preg[i]     <= sync1[i];
        PORT_CHG[i] <= (sync1[i] != preg[i]);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_A <= '0;
      OUT_B <= '0;
      WERR  <= 1'b0;
    end else begin
      OUT_A <= rd_a;
      OUT_B <= rd_b;
      WERR  <= wr_bad;
    end
  end

  for (genvar j = 0; j < OUT_PORTS; j++) begin : g_port_out
    assign PORT_OUT[j*WIDTH +: WIDTH] = mem[OUT_BASE + j];
  end

endmodule

// File: tb/tb_reg_file_io.sv
// Randomised scoreboard bench for reg_file_io: the driver pushes expected responses per edge,
// a monitor pops and compares one step after every rising edge.
module tb_reg_file_io;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int IN_PORTS  = 1;
  localparam int OUT_PORTS = 1;
  localparam int AW        = $clog2(DEPTH);
  localparam int PW        = IN_PORTS * WIDTH;
  localparam int OW        = OUT_PORTS * WIDTH;
  localparam int IN_BASE   = DEPTH - IN_PORTS;
  localparam int OUT_BASE  = IN_BASE - OUT_PORTS;
  localparam int EW        = 2*WIDTH + 1 + OW + IN_PORTS;
`ifdef REGF_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RST = 1'b0;
  logic                WE = 1'b0;
  logic [AW-1:0]       WSEL = '0;
  logic [WIDTH-1:0]    IN = '0;
  logic [AW-1:0]       RSEL_A = '0;
  logic [AW-1:0]       RSEL_B = '0;
  logic [WIDTH-1:0]    OUT_A;
  logic [WIDTH-1:0]    OUT_B;
  logic [PW-1:0]       PORT_IN = '0;
  logic [OW-1:0]       PORT_OUT;
  logic [IN_PORTS-1:0] PORT_CHG;
  logic                WERR;

  reg_file_io #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WSEL(WSEL), .IN(IN),
    .RSEL_A(RSEL_A), .RSEL_B(RSEL_B), .OUT_A(OUT_A), .OUT_B(OUT_B),
    .PORT_IN(PORT_IN), .PORT_OUT(PORT_OUT), .PORT_CHG(PORT_CHG), .WERR(WERR)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0]    exp_q[$];
  logic [WIDTH-1:0] mdl[DEPTH];
  logic [PW-1:0]    pin_hist[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain storage array plus input pins seen through a two-sample delay line.
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    pin_hist.delete();
    pin_hist.push_back('0);
    pin_hist.push_back('0);
  endtask

  function automatic logic [WIDTH-1:0] model_read(input int a, input bit legal, input int wa,
                                                  input logic [WIDTH-1:0] wd, input logic [PW-1:0] pold);
    if (a >= DEPTH) return '0;
    if (a >= IN_BASE) return pold[(a-IN_BASE)*WIDTH +: WIDTH];
    if (ZERO_EN && a == 0) return '0;
    if (legal && a == wa) return wd;
    return mdl[a];
  endfunction

  // Driver: applies one cycle of stimulus at the falling edge and queues the expected response.
  task automatic drive(input bit we, input int wa, input logic [WIDTH-1:0] wd,
                       input int ra, input int rb, input logic [PW-1:0] pin);
    logic [PW-1:0]       pold, pnew;
    logic [OW-1:0]       po;
    logic [IN_PORTS-1:0] chg;
    logic [WIDTH-1:0]    ea, eb;
    bit                  illegal, legal;
    @(negedge CLK);
    WE = we; WSEL = AW'(wa); IN = wd; RSEL_A = AW'(ra); RSEL_B = AW'(rb); PORT_IN = pin;
    illegal = we && (wa >= IN_BASE);
    legal   = we && !illegal && !(ZERO_EN && wa == 0);
    pold = pin_hist[pin_hist.size()-2];
    ea = model_read(ra, legal, wa, wd, pold);
    eb = model_read(rb, legal, wa, wd, pold);
    if (legal) mdl[wa] = wd;
    pin_hist.push_back(pin);
    if (pin_hist.size() > 3) void'(pin_hist.pop_front());
    pnew = pin_hist[pin_hist.size()-2];
    for (int i = 0; i < IN_PORTS; i++) chg[i] = (pnew[i*WIDTH +: WIDTH] != pold[i*WIDTH +: WIDTH]);
    for (int j = 0; j < OUT_PORTS; j++) po[j*WIDTH +: WIDTH] = mdl[OUT_BASE + j];
    exp_q.push_back({ea, eb, illegal, po, chg});
  endtask

  // Reset mid-cycle: outputs must clear without a clock and hold through an edge.
  task automatic do_reset();
    @(negedge CLK);
    WE = 1'b0;
    #2 RST = 1'b1;
    #1;
    check("rst_out_a", 64'(OUT_A), 64'd0);
    check("rst_out_b", 64'(OUT_B), 64'd0);
    check("rst_werr", 64'(WERR), 64'd0);
    check("rst_port_out", 64'(PORT_OUT), 64'd0);
    check("rst_port_chg", 64'(PORT_CHG), 64'd0);
    @(posedge CLK);
    #1;
    check("rst_hold_out_a", 64'(OUT_A), 64'd0);
    check("rst_hold_port_out", 64'(PORT_OUT), 64'd0);
    RST = 1'b0;
    model_reset();
  endtask

  // Scoreboard monitor
  always @(posedge CLK) begin
    logic [WIDTH-1:0]    ea, eb;
    logic                ew;
    logic [OW-1:0]       po;
    logic [IN_PORTS-1:0] ch;
    #1;
    if (exp_q.size() > 0) begin
      {ea, eb, ew, po, ch} = exp_q.pop_front();
      check("out_a", 64'(OUT_A), 64'(ea));
      check("out_b", 64'(OUT_B), 64'(eb));
      check("werr", 64'(WERR), 64'(ew));
      check("port_out", 64'(PORT_OUT), 64'(po));
      check("port_chg", 64'(PORT_CHG), 64'(ch));
    end
  end

  initial begin
    logic [PW-1:0] pin;
    model_reset();
    do_reset();

    for (int a = 0; a < DEPTH; a++) drive(1'b0, 0, '0, a, DEPTH-1-a, '0);

    drive(1'b1, 3, 8'h5A, 0, 1, '0);
    drive(1'b0, 0, 8'h00, 3, 3, '0);
    drive(1'b1, 2, 8'h11, 0, 0, '0);
    drive(1'b1, 7, 8'hC3, 7, 2, '0);
    drive(1'b0, 0, 8'h00, 7, 2, '0);
    drive(1'b1, 14, 8'hA5, 14, 14, '0);
    drive(1'b0, 0, 8'h00, 14, 0, '0);
    repeat (4) drive(1'b0, 0, 8'h00, 15, 15, 8'h3C);
    drive(1'b1, 15, 8'hFF, 15, 15, 8'h3C);
    drive(1'b0, 0, 8'h00, 15, 15, 8'h3C);
    drive(1'b1, 0, 8'h77, 0, 0, 8'h3C);
    drive(1'b0, 0, 8'h00, 0, 0, 8'h3C);

    pin = 8'h3C;
    for (int n = 0; n < 600; n++) begin
      int wa, ra, rb;
      if (n == 200 || n == 400) do_reset();
      if ($urandom_range(0, 7) == 0) pin = PW'($urandom);
      wa = $urandom_range(0, DEPTH-1);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH-1);
      rb = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH-1);
      drive(1'($urandom_range(0, 1)), wa, WIDTH'($urandom), ra, rb, pin);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge CLK);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_io.md
Name: reg_file_io

Overview:
- Parametrised successor to the CPU's single-port register file.
- Provides DEPTH x WIDTH storage with one write port and two registered read ports (A and B).
- The top of the address map holds memory-mapped I/O: IN_PORTS read-only input-port registers, each fed by a 2-flop synchroniser with change strobe, and OUT_PORTS writable output-port registers driven to pins.
- Sits between the instruction decoder (WSEL/RSEL) and the ALU operand muxes.

Parameters:
- WIDTH, 8, data width of every register and port.
- DEPTH, 16, total addressable registers; need not be a power of two; must be >= IN_PORTS+OUT_PORTS+1.
- IN_PORTS, 1, number of input-port registers at addresses DEPTH-IN_PORTS..DEPTH-1.
- OUT_PORTS, 1, number of output-port registers at addresses DEPTH-IN_PORTS-OUT_PORTS..DEPTH-IN_PORTS-1.
- AW, $clog2(DEPTH), derived localparam; address width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- WE  input  1  write enable.
- WSEL  input  AW  write address.
- IN  input  WIDTH  write data.
- RSEL_A  input  AW  read address, port A.
- RSEL_B  input  AW  read address, port B.
- OUT_A  output  WIDTH  registered read data A.
- OUT_B  output  WIDTH  registered read data B.
- PORT_IN  input  IN_PORTS*WIDTH  asynchronous external inputs; port i occupies bits [i*WIDTH +: WIDTH].
- PORT_OUT  output  OUT_PORTS*WIDTH  output-port register contents; port j at bits [j*WIDTH +: WIDTH], port j = address DEPTH-IN_PORTS-OUT_PORTS+j.
- PORT_CHG  output  IN_PORTS  one-cycle pulse when input-port register i takes a new value.
- WERR  output  1  registered one-cycle flag for an illegal write.

Behaviour:
- Reset (RST=1, asynchronous): all storage, synchroniser stages, OUT_A, OUT_B, PORT_OUT, PORT_CHG and WERR go to 0. They hold 0 while RST is high.
- Write: on a rising edge with WE=1 and WSEL at a general or output-port address, the register at WSEL takes IN.
- Illegal write: WE=1 with WSEL at an input-port address, or WSEL>=DEPTH.
  - The write is dropped.
  - WERR=1 for the following cycle.
  - WERR=0 every other cycle.
- Read latency is 1 cycle: on each edge, OUT_A takes the contents of RSEL_A, and OUT_B the contents of RSEL_B, as they were before that edge.
- Write-first bypass: if WE=1, the write is legal, and WSEL equals RSEL_A (or RSEL_B) on the same edge, that output takes IN instead of the old contents. Both outputs can bypass on the same edge.
- Out-of-range read (RSEL>=DEPTH) returns 0.
- Input port i:
  - sync1[i] <= PORT_IN slice on each edge; preg[i] <= sync1[i]. preg[i] is the value read at its address.
  - PORT_CHG[i] <= (sync1[i] != preg[i]), so it is high in exactly the cycle preg[i] first shows a new value.
  - PORT_IN latency is 2 edges to preg and 3 edges to OUT_A/OUT_B.
  - Input ports are never bypassed.
- A read of an address being read-and-written in the same cycle follows the bypass rule. A read of an input port sees preg before the edge.
- PORT_OUT is the output-port register contents directly; there is no extra flop, so it updates on the write edge.
- Reset asserted mid-operation clears everything immediately. The first edge after release behaves as a normal cycle, with any write honoured.

Optional Feature:
- REGF_ZERO_REG_EN defined:
  - Address 0 is hardwired to 0.
  - Writes to address 0 are silently dropped, with no WERR and no bypass, so a read of 0 always returns 0.
  - DEPTH must be >= IN_PORTS+OUT_PORTS+2.
- Undefined: address 0 is an ordinary general register.

Test Plan:
- Defaults. RST pulse mid-cycle, then read addresses 0..15 -> OUT_A=OUT_B=0, PORT_OUT=0, WERR=0 immediately on RST rise, no clock needed.
- Write and read back. Write 0x5A to addr 3; next cycle RSEL_A=3, RSEL_B=3 -> both 0x5A one edge later.
- Bypass on both ports. WE=1, WSEL=7, IN=0xC3, RSEL_A=7, RSEL_B=2 (holding 0x11) on the same edge -> OUT_A=0xC3, OUT_B=0x11.
- Output port. Write 0xA5 to addr 14 -> PORT_OUT=0xA5 after that edge, WERR stays 0.
- Input port. PORT_IN steps 0x00->0x3C, RSEL_A=15 held:
  - PORT_CHG=1 for exactly one cycle, after the 2nd edge.
  - OUT_A=0x3C after the 3rd edge.
  - Then write 0xFF to addr 15 -> WERR=1 for one cycle and OUT_A stays 0x3C.
- Zero register. Write 0x77 to addr 0:
  - With REGF_ZERO_REG_EN, read -> 0x00 and WERR=0.
  - Without it, read -> 0x77.
